frame_scheduler: RTL



---
 rtl/graphics_pkg.sv | 22 ++
 rtl/zbuf_clear_counter.sv | 50 +++++
 rtl/frame_scheduler.sv | 129 ++++++++++++
 3 files changed

// File: rtl/graphics_pkg.sv
// Shared graphics package: pixel point type, z-buffer clear value and the
// frame scheduler state encoding used by frame_scheduler.
package graphics_pkg;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic        [31:0] z;
  } point_val_t;

  // Depth buffer is cleared to all ones (farthest depth); replicated to word width by users.
  localparam logic ZCLEAR_BIT = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR_Z,
    S_START,
    S_RENDER,
    S_READY
  } frame_sched_state;

endpackage

// File: rtl/zbuf_clear_counter.sv
// Z-buffer clear sweep: after start, writes addresses 0..SIZE-1 one per cycle
// and flags the final write with last.
module zbuf_clear_counter #(
  parameter int SIZE      = 10000,
  parameter int ADDR_BITS = $clog2(SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [ADDR_BITS-1:0] addr,
  output logic                 wr_en,
  output logic                 last
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(SIZE - 1);

  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 wr_en_q, wr_en_d;

  // Address holds its last value once the sweep ends.
  always_comb begin
    addr_d  = addr_q;
    wr_en_d = wr_en_q;
    if (start) begin
      addr_d  = '0;
      wr_en_d = 1'b1;
    end else if (wr_en_q) begin
      if (addr_q == LAST_ADDR) begin
        wr_en_d = 1'b0;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wr_en_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wr_en_q <= wr_en_d;
    end
  end

  assign addr  = addr_q;
  assign wr_en = wr_en_q;
  assign last  = wr_en_q && (addr_q == LAST_ADDR);

endmodule

// File: rtl/frame_scheduler.sv
// Frame scheduler: sequences z-clear, rasterizer start and vsync-aligned buffer swap.
// Optional FRAME_SCHED_STATS_EN adds a saturating drop_count output for dropped vsyncs.
module frame_scheduler
  import graphics_pkg::*;
#(
  parameter int FRAMEBUFFER_SIZE  = 10000,
  parameter int ZBUFFER_ADDR_BITS = $clog2(FRAMEBUFFER_SIZE),
  parameter int ZBUFFER_DATA_BITS = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         vsync,
  output logic                         frame_start,
  input  logic                         frame_done,
  output logic                         zclr_wr_en,
  output logic [ZBUFFER_ADDR_BITS-1:0] zclr_wr_addr,
  output logic [ZBUFFER_DATA_BITS-1:0] zclr_wr_data,
  output logic                         front_buf_sel,
  output logic                         busy,
  output logic [15:0]                  frame_count
`ifdef FRAME_SCHED_STATS_EN
  ,
  output logic [15:0]                  drop_count
`endif
);

  frame_sched_state state_q, state_d;
  logic             frame_start_q, frame_start_d;
  logic             front_buf_sel_q, front_buf_sel_d;
  logic             busy_q, busy_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic             clear_start, clear_last, swap;

  zbuf_clear_counter #(
    .SIZE      (FRAMEBUFFER_SIZE),
    .ADDR_BITS (ZBUFFER_ADDR_BITS)
  ) u_clear (
    .clk   (clk),
    .rst   (rst),
    .start (clear_start),
    .addr  (zclr_wr_addr),
    .wr_en (zclr_wr_en),
    .last  (clear_last)
  );

  always_comb begin
    state_d     = state_q;
    clear_start = 1'b0;
    swap        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (vsync && enable) begin
          state_d     = S_CLEAR_Z;
          clear_start = 1'b1;
        end
      end
      S_CLEAR_Z: if (clear_last) state_d = S_START;
      S_START:   state_d = S_RENDER;
      S_RENDER:  if (frame_done) state_d = S_READY;
      S_READY: begin
        if (vsync) begin
          swap = 1'b1;
          if (enable) begin
            state_d     = S_CLEAR_Z;
            clear_start = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Registered outputs are derived from the next state so they line up with it.
    frame_start_d   = (state_d == S_START);
    busy_d          = !((state_d == S_IDLE) || (state_d == S_READY));
    front_buf_sel_d = front_buf_sel_q ^ swap;
    frame_count_d   = frame_count_q + {15'd0, swap};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      frame_start_q   <= 1'b0;
      front_buf_sel_q <= 1'b0;
      busy_q          <= 1'b0;
      frame_count_q   <= 16'd0;
    end else begin
      state_q         <= state_d;
      frame_start_q   <= frame_start_d;
      front_buf_sel_q <= front_buf_sel_d;
      busy_q          <= busy_d;
      frame_count_q   <= frame_count_d;
    end
  end

  assign frame_start   = frame_start_q;
  assign front_buf_sel = front_buf_sel_q;
  assign busy          = busy_q;
  assign frame_count   = frame_count_q;
  assign zclr_wr_data  = {ZBUFFER_DATA_BITS{ZCLEAR_BIT}};

`ifdef FRAME_SCHED_STATS_EN
  logic [15:0] drop_count_q, drop_count_d;
  logic        vsync_dropped;

  // A vsync while a frame is still being cleared, started or rendered is lost.
  always_comb begin
    vsync_dropped = vsync && ((state_q == S_CLEAR_Z) || (state_q == S_START) ||
                              (state_q == S_RENDER));
    drop_count_d  = drop_count_q;
    if (vsync_dropped && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count_q <= 16'd0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  assign drop_count = drop_count_q;
`endif

endmodule
